// File: rtl/mdu_iter.sv
// mdu_iter -- iterative multiply/divide unit with private HI/LO registers.
//
// Handles MULT/MULTU/DIV/DIVU/MTHI/MTLO for a multicycle MIPS datapath.
// Multiply is a radix-2^MUL_STEP_BITS shift-add on operand magnitudes.
// Divide is restoring, one quotient bit per cycle.
// MTHI/MTLO write HI/LO directly at the start edge and never raise busy.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   start   request, sampled only while busy=0
//   op      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//   a       rs operand: multiplicand / dividend / MTHI-MTLO data
//   b       rt operand: multiplier / divisor
//   cancel  aborts the operation in flight; ignored while idle
//   busy    operation in flight
//   done    one-cycle pulse, hi/lo were written at the preceding edge
//   dz      valid with done: divide by zero
//   hi, lo  HI / LO registers
module mdu_iter #(
  parameter int WIDTH         = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int NM = WIDTH / MUL_STEP_BITS;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] MUL_LAST = CW'(NM - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // multiply accumulator
  logic [2*WIDTH-1:0] mcand;    // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier;   // multiplier, shifted right each step
  logic [WIDTH-1:0]   quo;      // dividend in, quotient out (also holds a on divide-by-zero)
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvsr;
  logic               neg_q;    // negate product / quotient at FIX
  logic               neg_r;    // negate remainder at FIX
  logic               is_mul;
  logic               dz_pend;

  // Signed variants have op[0]=0 (MULT, DIV).
  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign signed_op = ~op[0];
  // Negating the most negative value yields the same bit pattern, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

  assign busy = (state != S_IDLE);

  // Multiply step: add the multiplicand weighted by the low multiplier bits.
  logic [2*WIDTH-1:0] partial;
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it holding its old value and no latch is inferred.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_STEP_BITS; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  // Restoring divide step: trial subtract of the divisor from the shifted remainder.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr};

  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;
  assign prod_res = neg_q ? -acc : acc;
  assign quo_res  = neg_q ? -quo : quo;
  assign rem_res  = neg_r ? -rem : rem;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      is_mul  <= 1'b0;
      dz_pend <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              OP_MULT, OP_MULTU: begin
                acc     <= '0;
                mcand   <= {{WIDTH{1'b0}}, a_mag};
                mplier  <= b_mag;
                neg_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r   <= 1'b0;
                is_mul  <= 1'b1;
                dz_pend <= 1'b0;
                cnt     <= '0;
                state   <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                is_mul <= 1'b0;
                cnt    <= '0;
                if (b == '0) begin
                  // Skip iteration; FIX writes hi<=a, lo<=all ones.
                  quo     <= a;
                  dz_pend <= 1'b1;
                  state   <= S_FIX;
                end else begin
                  rem     <= '0;
                  quo     <= a_mag;
                  dvsr    <= b_mag;
                  neg_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r   <= signed_op & a[WIDTH-1];
                  dz_pend <= 1'b0;
                  state   <= S_DIV;
                end
              end
              default: ;
            endcase
          end
        end

        S_MUL: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            acc    <= acc + partial;
            mcand  <= mcand << MUL_STEP_BITS;
            mplier <= mplier >> MUL_STEP_BITS;
            cnt    <= cnt + 1'b1;
            if (cnt == MUL_LAST) state <= S_FIX;
          end
        end

        S_DIV: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            if (!diff[WIDTH]) begin
              rem <= diff[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (cnt == DIV_LAST) state <= S_FIX;
          end
        end

        S_FIX: begin
          // cancel wins over the result write in the same cycle.
          state <= S_IDLE;
          if (!cancel) begin
            done <= 1'b1;
            dz   <= dz_pend;
            if (dz_pend) begin
              hi <= quo;
              lo <= '1;
            end else if (is_mul) begin
              hi <= prod_res[2*WIDTH-1:WIDTH];
              lo <= prod_res[WIDTH-1:0];
            end else begin
              hi <= rem_res;
              lo <= quo_res;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter: two instances (MUL_STEP_BITS=1 and 4) share stimulus.
// Directed vector table, hand-written corner sequences, and random operations
// checked against an arithmetic reference model.
module tb_mdu_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         cancel;

  logic         busy1, done1, dz1;
  logic [W-1:0] hi1, lo1;
  logic         busy4, done4, dz4;
  logic [W-1:0] hi4, lo4;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W), .MUL_STEP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy1), .done(done1), .dz(dz1), .hi(hi1), .lo(lo1)
  );

  mdu_iter #(.WIDTH(W), .MUL_STEP_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy4), .done(done4), .dz(dz4), .hi(hi4), .lo(lo4)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           bc1;
    int           bc4;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start pulse spans one rising edge; returns at the falling edge after it.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles of both instances until each reports done (bounded).
  task automatic wait_done(output int bc1, output int bc4,
                           output logic [W-1:0] h1, output logic [W-1:0] l1, output logic d1,
                           output logic [W-1:0] h4, output logic [W-1:0] l4, output logic d4,
                           output bit got1, output bit got4);
    bc1 = 0; bc4 = 0; got1 = 0; got4 = 0;
    h1 = 'x; l1 = 'x; d1 = 'x; h4 = 'x; l4 = 'x; d4 = 'x;
    for (int k = 0; k < 80 && !(got1 && got4); k++) begin
      if (busy1) bc1++;
      if (busy4) bc4++;
      if (done1 && !got1) begin got1 = 1; h1 = hi1; l1 = lo1; d1 = dz1; end
      if (done4 && !got4) begin got4 = 1; h4 = hi4; l4 = lo4; d4 = dz4; end
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    int bc1, bc4;
    logic [W-1:0] h1, l1, h4, l4;
    logic d1, d4;
    bit g1, g4;
    issue(v.op, v.a, v.b);
    wait_done(bc1, bc4, h1, l1, d1, h4, l4, d4, g1, g4);
    check({tag, " done1"}, g1, 1);
    check({tag, " hi1"}, h1, v.hi);
    check({tag, " lo1"}, l1, v.lo);
    check({tag, " dz1"}, d1, v.dz);
    check({tag, " busy1"}, bc1, v.bc1);
    check({tag, " done4"}, g4, 1);
    check({tag, " hi4"}, h4, v.hi);
    check({tag, " lo4"}, l4, v.lo);
    check({tag, " dz4"}, d4, v.dz);
    check({tag, " busy4"}, bc4, v.bc4);
  endtask

  // Reference model: plain wide arithmetic from the architectural definition.
  function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    vec_t   v;
    longint sx, sy;
    logic [63:0] p;
    int     qx, qy;
    v.op = o; v.a = x; v.b = y; v.dz = 1'b0;
    if (o == 3'd0 || o == 3'd1) begin
      if (o == 3'd0) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = sx * sy;
      end else begin
        p = {32'b0, x} * {32'b0, y};
      end
      v.hi = p[63:32]; v.lo = p[31:0];
      v.bc1 = 33; v.bc4 = 9;
    end else begin
      v.bc1 = 33; v.bc4 = 33;
      if (y == 0) begin
        v.hi = x; v.lo = '1; v.dz = 1'b1;
        v.bc1 = 1; v.bc4 = 1;
      end else if (o == 3'd2) begin
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          v.lo = x; v.hi = 0;
        end else begin
          qx = x; qy = y;
          v.lo = qx / qy;
          v.hi = qx % qy;
        end
      end else begin
        v.lo = x / y;
        v.hi = x % y;
      end
    end
    return v;
  endfunction

  initial begin
    vec_t tbl[8];
    vec_t v;
    int bc1, bc4;
    logic [W-1:0] h1, l1, h4, l4;
    logic d1, d4;
    bit g1, g4, seen_done;

    //        op    a             b             hi            lo            dz  bc1 bc4
    tbl[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 33, 9};
    tbl[1] = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33, 9};
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33, 33};
    tbl[3] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       0, 33, 33};
    tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 33, 33};
    tbl[5] = '{3'd2, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1, 1,  1};
    tbl[6] = '{3'd3, 32'd7,        32'hFFFFFFFF, 32'd7,        32'd0,        0, 33, 33};
    tbl[7] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 33, 9};

    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset hi", hi1, 0);
    check("reset lo", lo1, 0);
    check("reset busy", busy1, 0);
    check("reset done", done1, 0);
    check("reset dz", dz1, 0);
    check("reset busy4", busy4, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_and_check($sformatf("vec%0d", i), tbl[i]);

    // MTHI / MTLO write at the start edge without raising busy.
    issue(3'd4, 32'hAAAA5555, 32'h0);
    check("mthi hi", hi1, 32'hAAAA5555);
    check("mthi busy", busy1, 0);
    check("mthi done", done1, 0);
    issue(3'd5, 32'h0F0F0F0F, 32'h0);
    check("mtlo lo", lo1, 32'h0F0F0F0F);
    check("mtlo hi kept", hi1, 32'hAAAA5555);
    check("mtlo busy", busy1, 0);

    // Illegal op has no effect.
    issue(3'd7, 32'h12345678, 32'd9);
    check("illegal busy", busy1, 0);
    check("illegal hi", hi1, 32'hAAAA5555);
    check("illegal lo", lo1, 32'h0F0F0F0F);

    // Second start while busy is ignored; result belongs to the first op.
    issue(3'd1, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hDEADBEEF; b = 32'h0;
    @(negedge clk);
    start = 1'b0;
    check("busy start hi kept", hi1, 32'hAAAA5555);
    check("busy start busy", busy1, 1);
    wait_done(bc1, bc4, h1, l1, d1, h4, l4, d4, g1, g4);
    check("ignored done", g1, 1);
    check("ignored hi", h1, 0);
    check("ignored lo", l1, 15);
    check("ignored dz", d1, 0);
    check("ignored busy rest", bc1, 29);
    check("ignored hi4", h4, 0);
    check("ignored lo4", l4, 15);
    check("ignored busy4 rest", bc4, 5);

    // Cancel a divide mid-flight.
    issue(3'd2, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    check("cancel pre busy", busy1, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel busy", busy1, 0);
    seen_done = 0;
    for (int k = 0; k < 5; k++) begin
      if (done1 || done4) seen_done = 1;
      @(negedge clk);
    end
    check("cancel no done", seen_done, 0);
    check("cancel hi", hi1, 0);
    check("cancel lo", lo1, 15);

    // Cancel in the FIX cycle beats the divide-by-zero write.
    issue(3'd2, 32'h12345678, 32'h0);
    check("fixcancel pre busy", busy1, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("fixcancel busy", busy1, 0);
    check("fixcancel done", done1, 0);
    check("fixcancel dz", dz1, 0);
    check("fixcancel hi", hi1, 0);
    check("fixcancel lo", lo1, 15);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   o;
      logic [W-1:0] x, y;
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 7))
        0:       y = 0;
        1, 2:    y = $urandom_range(1, 20);
        3:       y = -$urandom_range(1, 20);
        default: y = $urandom;
      endcase
      v = model(o, x, y);
      run_and_check($sformatf("rnd%0d op%0d a=%h b=%h", i, o, x, y), v);
    end

    // Asynchronous reset in the middle of a multiply.
    issue(3'd4, 32'h5, 32'h0);
    issue(3'd5, 32'h6, 32'h0);
    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    repeat (11) @(negedge clk);
    check("areset pre busy", busy1, 1);
    check("areset pre hi", hi1, 5);
    #2 rst = 1'b1;
    #1;
    check("areset hi", hi1, 0);
    check("areset lo", lo1, 0);
    check("areset busy", busy1, 0);
    check("areset done", done1, 0);
    check("areset dz", dz1, 0);
    check("areset busy4", busy4, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
